// File: rtl/hex_disp_ctrl_pkg.sv
// Shared types and active-low seven-segment glyphs (bit 6 = g ... bit 0 = a)
// for the UART hex display controller.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_HI = 2'd1,
        SHIFT_LO = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_A     = 7'b000_1000;
    localparam logic [6:0] SEG_B     = 7'b000_0011;
    localparam logic [6:0] SEG_C     = 7'b100_0110;
    localparam logic [6:0] SEG_D     = 7'b010_0001;
    localparam logic [6:0] SEG_E     = 7'b000_0110;
    localparam logic [6:0] SEG_F     = 7'b000_1110;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/hex_disp_ctrl_seg_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Scrolling hex readout of the UART byte stream: each byte shifts two nibbles
// into the digit buffer; receive errors hold a dash pattern for ERR_CYCLES.
module hex_disp_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int ERR_CYCLES = 50_000_000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    output logic                            in_ready,
    input  logic                            clear,
    input  logic                            rx_err,
    output logic [7*NUM_DIGITS-1:0]         hex_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
    output logic                            err_active
);

    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int DC_W  = $clog2(NUM_DIGITS + 1);
    localparam int CNT_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [DC_W-1:0]  DC_MAX     = DC_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ERR_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [BUF_W-1:0]        digits, digits_nxt;
    logic [DC_W-1:0]         count, count_nxt;
    logic [CNT_W-1:0]        err_cnt, err_cnt_nxt;
    logic [7:0]              byte_q;
    logic [3:0]              nibble;
    logic                    accept;
    logic [7*NUM_DIGITS-1:0] glyphs;
    logic [7*NUM_DIGITS-1:0] hex_nxt;
    logic [7*NUM_DIGITS-1:0] hex_p1;

    // clear and rx_err outrank a handshake, so they must block in_ready directly
    assign in_ready    = reset_n && (state == IDLE) && !clear && !rx_err;
    assign accept      = in_valid && in_ready;
    assign err_active  = (state == ERROR);
    assign digit_count = count;
    assign hex_out     = hex_p1;

    always_comb begin
        state_nxt   = state;
        digits_nxt  = digits;
        count_nxt   = count;
        err_cnt_nxt = err_cnt;
        nibble      = (state == SHIFT_HI) ? byte_q[7:4] : byte_q[3:0];

        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT_HI;
            end
            SHIFT_HI, SHIFT_LO: begin
                digits_nxt = {digits[BUF_W-5:0], nibble};
                if (count != DC_MAX) count_nxt = count + 1'b1;
                state_nxt = (state == SHIFT_HI) ? SHIFT_LO : IDLE;
            end
            ERROR: begin
                if (err_cnt == '0) state_nxt = IDLE;
                else               err_cnt_nxt = err_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (clear) begin
            digits_nxt = '0;
            count_nxt  = '0;
            if (state != ERROR) state_nxt = IDLE;
        end

        // an error abandons any shift: the buffer keeps what it already holds
        if (rx_err) begin
            state_nxt   = ERROR;
            err_cnt_nxt = CNT_RELOAD;
            if (!clear) begin
                digits_nxt = digits;
                count_nxt  = count;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg_decode u_dec (
            .nibble (digits[4*g +: 4]),
            .seg    (glyphs[7*g +: 7])
        );
    end

    always_comb begin
        hex_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (state == ERROR)        hex_nxt[7*k +: 7] = SEG_DASH;
            else if (k < int'(count))  hex_nxt[7*k +: 7] = glyphs[7*k +: 7];
            else                       hex_nxt[7*k +: 7] = SEG_BLANK;
        end
    end

    // stage p1: control state and registered segment drive
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            digits  <= '0;
            count   <= '0;
            err_cnt <= '0;
            hex_p1  <= '1;
        end else begin
            state   <= state_nxt;
            digits  <= digits_nxt;
            count   <= count_nxt;
            err_cnt <= err_cnt_nxt;
            hex_p1  <= hex_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) byte_q <= in_data;
    end

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Randomised and directed bench for hex_disp_ctrl against a nibble-queue model.
module tb_hex_disp_ctrl;

    localparam int ND = 6;
    localparam int EC = 10;
    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [6:0] DASH = 7'h3F;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [7:0]           in_data = 8'h00;
    logic                 in_ready;
    logic                 clear = 1'b0;
    logic                 rx_err = 1'b0;
    logic [7*ND-1:0]      hex_out;
    logic [2:0]           digit_count;
    logic                 err_active;

    int checks = 0;
    int errors = 0;

    // reference model: loaded digits, pending nibbles, remaining error cycles
    int              mdig [ND];
    int              mcnt = 0;
    int              merr = 0;
    int              mpend [$];
    logic [7*ND-1:0] mhex = '1;

    hex_disp_ctrl #(.NUM_DIGITS(ND), .ERR_CYCLES(EC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clear       (clear),
        .rx_err      (rx_err),
        .hex_out     (hex_out),
        .digit_count (digit_count),
        .err_active  (err_active)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_ready();
        return reset_n && (merr == 0) && (mpend.size() == 0) && !clear && !rx_err;
    endfunction

    function automatic void clear_model();
        foreach (mdig[k]) mdig[k] = 0;
        mcnt = 0;
    endfunction

    function automatic void shift_in(int n);
        for (int k = ND - 1; k > 0; k--) mdig[k] = mdig[k-1];
        mdig[0] = n;
        if (mcnt < ND) mcnt++;
    endfunction

    task automatic model_edge();
        bit hs;
        hs = in_valid && exp_ready();
        if (!reset_n) begin
            clear_model();
            merr = 0;
            mpend.delete();
            mhex = '1;
            return;
        end
        for (int k = 0; k < ND; k++)
            mhex[7*k +: 7] = (merr > 0) ? DASH : ((k < mcnt) ? GLY[mdig[k]] : 7'h7F);
        if (rx_err) begin
            mpend.delete();
            merr = EC;
            if (clear) clear_model();
        end else begin
            if (merr > 0) merr--;
            if (clear) begin
                clear_model();
                mpend.delete();
            end else if (mpend.size() > 0) begin
                shift_in(mpend.pop_front());
            end else if (hs) begin
                mpend.push_back(int'(in_data[7:4]));
                mpend.push_back(int'(in_data[3:0]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        #1;
        checks++; if (hex_out !== {ND{7'h7F}}) begin errors++; $display("FAIL reset_hex got %h want %h", hex_out, {ND{7'h7F}}); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", digit_count); end
        checks++; if (err_active !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_active); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_two_bytes();
        logic [7:0] bytes [2];
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = bytes[b];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL two_ready_pre%0d got %b want 1", b, in_ready); end
            cycle();
            in_valid = 1'b0;
            for (int c = 0; c < 2; c++) begin
                #1;
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_busy%0d_%0d got %b want 0", b, c, in_ready); end
                cycle();
            end
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL two_ready_post%0d got %b want 1", b, in_ready); end
            if (b == 0) begin
                checks++; if (hex_out !== {{5{7'h7F}}, 7'h08}) begin errors++; $display("FAIL two_hi_latency got %h want %h", hex_out, {{5{7'h7F}}, 7'h08}); end
            end
        end
        cycle();
        checks++; if (hex_out !== {7'h7F, 7'h7F, 7'h08, 7'h12, 7'h30, 7'h46}) begin errors++; $display("FAIL two_hex got %h want %h", hex_out, {7'h7F, 7'h7F, 7'h08, 7'h12, 7'h30, 7'h46}); end
        checks++; if (hex_out !== mhex) begin errors++; $display("FAIL two_model got %h want %h", hex_out, mhex); end
        checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL two_count got %0d want 4", digit_count); end
    endtask

    task automatic test_saturate();
        logic [7:0] bytes [4];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        #1;
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", digit_count); end
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            in_data  = bytes[b];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready%0d got %b want 1", b, in_ready); end
            cycle();
            in_valid = 1'b0;
            repeat (2) cycle();
        end
        cycle();
        checks++; if (hex_out !== {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}) begin errors++; $display("FAIL sat_hex got %h want %h", hex_out, {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}); end
        checks++; if (digit_count !== 3'd6) begin errors++; $display("FAIL sat_count got %0d want 6", digit_count); end
    endtask

    task automatic test_error();
        logic [7*ND-1:0] saved;
        saved  = mhex;
        rx_err = 1'b1;
        cycle();
        rx_err = 1'b0;
        for (int i = 1; i <= EC; i++) begin
            #1;
            checks++; if (err_active !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL err_hold%0d got act=%b rdy=%b want act=1 rdy=0", i, err_active, in_ready); end
            if (i >= 2) begin
                checks++; if (hex_out !== {ND{DASH}}) begin errors++; $display("FAIL err_dash%0d got %h want %h", i, hex_out, {ND{DASH}}); end
            end
            cycle();
        end
        checks++; if (err_active !== 1'b0) begin errors++; $display("FAIL err_end got %b want 0", err_active); end
        cycle();
        checks++; if (hex_out !== saved) begin errors++; $display("FAIL err_restore got %h want %h", hex_out, saved); end
        checks++; if (digit_count !== 3'd6) begin errors++; $display("FAIL err_count got %0d want 6", digit_count); end
    endtask

    task automatic test_error_restart();
        logic [7*ND-1:0] saved;
        int n;
        saved  = mhex;
        rx_err = 1'b1;
        cycle();
        rx_err = 1'b0;
        repeat (4) cycle();
        rx_err = 1'b1;
        #1;
        checks++; if (err_active !== 1'b1) begin errors++; $display("FAIL restart_active got %b want 1", err_active); end
        cycle();
        rx_err = 1'b0;
        n = 0;
        while (err_active === 1'b1 && n < 20) begin
            n++;
            if (n >= 2) begin
                checks++; if (hex_out !== {ND{DASH}}) begin errors++; $display("FAIL restart_dash%0d got %h want %h", n, hex_out, {ND{DASH}}); end
            end
            cycle();
        end
        checks++; if (n != EC) begin errors++; $display("FAIL restart_len got %0d want %0d", n, EC); end
        cycle();
        checks++; if (hex_out !== saved) begin errors++; $display("FAIL restart_restore got %h want %h", hex_out, saved); end
    endtask

    task automatic test_clear_vs_valid();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        clear    = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", in_ready); end
        cycle();
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d want 0", digit_count); end
        repeat (3) cycle();
        checks++; if (hex_out !== {ND{7'h7F}}) begin errors++; $display("FAIL clr_hex got %h want %h", hex_out, {ND{7'h7F}}); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clr_noload got %0d want 0", digit_count); end
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1;
        in_data  = 8'hE7;
        cycle();
        in_valid = 1'b0;
        cycle();
        reset_n = 1'b0;
        cycle();
        checks++; if (hex_out !== {ND{7'h7F}} || digit_count !== 3'd0 || err_active !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid got hex=%h cnt=%0d err=%b rdy=%b want all-7F/0/0/0", hex_out, digit_count, err_active, in_ready);
        end
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h9B;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        checks++; if (hex_out !== {{4{7'h7F}}, 7'h10, 7'h03}) begin errors++; $display("FAIL rst_reload got %h want %h", hex_out, {{4{7'h7F}}, 7'h10, 7'h03}); end
        checks++; if (digit_count !== 3'd2) begin errors++; $display("FAIL rst_count got %0d want 2", digit_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            clear    = $urandom_range(0, 31) == 0;
            rx_err   = $urandom_range(0, 63) == 0;
            reset_n  = $urandom_range(0, 199) != 0;
            #1;
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready@%0d got %b want %b", i, in_ready, exp_ready()); end
            checks++; if (err_active !== (merr > 0)) begin errors++; $display("FAIL rnd_err@%0d got %b want %b", i, err_active, merr > 0); end
            checks++; if (int'(digit_count) != mcnt) begin errors++; $display("FAIL rnd_count@%0d got %0d want %0d", i, digit_count, mcnt); end
            checks++; if (hex_out !== mhex) begin errors++; $display("FAIL rnd_hex@%0d got %h want %h", i, hex_out, mhex); end
            cycle();
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        rx_err   = 1'b0;
        reset_n  = 1'b1;
    endtask

    initial begin
        foreach (mdig[k]) mdig[k] = 0;
        test_reset();
        test_two_bytes();
        test_saturate();
        test_error();
        test_error_restart();
        test_clear_vs_valid();
        test_reset_mid_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
